atm_timer: RTL and testbench

Inactivity/session timeout counter for the ATM bank-system controller. While `start` is held high it counts clock cycles and raises `timeout` once the count reaches a programmable 32-bit `threshold`. The controller uses `restart` to re-arm it on user activity, and deasserts `start` to disarm it. The module name is `atm_timer`. Ports are positional in the order listed below.

---
 rtl/atm_timer.sv | 38 +++
 tb/tb_atm_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/atm_timer.sv
// Inactivity timeout counter: counts cycles while start is held and flags timeout once count >= threshold.
// Single-cycle register, combinational timeout output; no backpressure, the counter saturates at threshold.
module atm_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        restart,
  input  logic [31:0] threshold,
  output logic        timeout
);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        at_limit;

  assign at_limit = (count_q >= threshold);

  always_comb begin
    count_d = count_q;
    if (!start || restart) begin
      count_d = '0;
    end else if (!at_limit) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // rst term forces timeout low during reset even if threshold is 0
  assign timeout = rst & start & at_limit;

endmodule

// File: tb/tb_atm_timer.sv
// Directed plus randomized bench for atm_timer, checked against a cycle-level behavioural model.
module tb_atm_timer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        restart;
  logic [31:0] threshold;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  longint unsigned m_cnt = 0;

  atm_timer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .restart  (restart),
    .threshold(threshold),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_timeout();
    return rst && start && (m_cnt >= longint'(threshold));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] mc;
    mc = m_cnt[31:0];
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, model_timeout()});
    check({tag, "_count"}, dut.count_q, mc);
  endtask

  // One rising edge; model applies the priority rules to the inputs present at the edge.
  task automatic tick();
    logic r, s, rs;
    longint unsigned th;
    r  = rst;
    s  = start;
    rs = restart;
    th = longint'(threshold);
    @(posedge clk);
    if (!r || !s || rs) m_cnt = 0;
    else if (m_cnt < th) m_cnt = m_cnt + 1;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; restart = 1'b0; threshold = 32'd10;
    #1;
    check("reset_async", {31'd0, timeout}, 32'd0);
    tick();
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_count", dut.count_q, 32'd0);

    rst = 1'b1; start = 1'b1; restart = 1'b1;
    tick();
    check("rearm_timeout", {31'd0, timeout}, 32'd0);
    check("rearm_count", dut.count_q, 32'd0);

    restart = 1'b0;
    ticks(9);
    check("limit_minus1", {31'd0, timeout}, 32'd0);
    check("limit_minus1_cnt", dut.count_q, 32'd9);
    tick();
    check("limit_hit", {31'd0, timeout}, 32'd1);
    check("limit_hit_cnt", dut.count_q, 32'd10);

    start = 1'b0;
    #1;
    check("start_fall_comb", {31'd0, timeout}, 32'd0);
    tick();
    start = 1'b1;
    ticks(6);
    check("disarm_cleared", {31'd0, timeout}, 32'd0);
    check("disarm_cleared_cnt", dut.count_q, 32'd6);
    ticks(11);
    check("saturate_timeout", {31'd0, timeout}, 32'd1);
    check("saturate_cnt", dut.count_q, 32'd10);

    start = 1'b0;
    tick();
    start = 1'b1;
    ticks(16);
    check("second_cycle", {31'd0, timeout}, 32'd1);
    restart = 1'b1;
    tick();
    check("restart_clears", {31'd0, timeout}, 32'd0);
    check("restart_clears_cnt", dut.count_q, 32'd0);

    threshold = 32'd0;
    #1;
    check("thr0_restart_held", {31'd0, timeout}, 32'd1);
    tick();
    check("thr0_after_edge", {31'd0, timeout}, 32'd1);
    restart = 1'b0;
    tick();
    check("thr0_hold_cnt", dut.count_q, 32'd0);

    threshold = 32'd100;
    ticks(20);
    check("pre_lower", {31'd0, timeout}, 32'd0);
    check("pre_lower_cnt", dut.count_q, 32'd20);
    threshold = 32'd5;
    #1;
    check("lowered_same_cycle", {31'd0, timeout}, 32'd1);
    tick();
    check("lowered_held_cnt", dut.count_q, 32'd20);
    threshold = 32'd100;
    #1;
    check("raised_falls", {31'd0, timeout}, 32'd0);
    tick();
    check("raised_resumes_cnt", dut.count_q, 32'd21);

    threshold = 32'd50;
    ticks(3);
    #2;
    rst = 1'b0;
    m_cnt = 0;
    #1;
    check("async_rst_timeout", {31'd0, timeout}, 32'd0);
    check("async_rst_cnt", dut.count_q, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_first_inc", dut.count_q, 32'd1);

    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 15) != 0);
      restart = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) threshold = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        m_cnt = 0;
        #1;
        check_all("rand_rst");
        rst = 1'b1;
      end
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
